// File: rtl/alu_seq_if.sv
// alu_seq_if: issue/result bundle between the control unit (master) and alu_seq (slave).
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [3:0]       ALUCtr;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ALURes;
  logic             Zero;
  logic             Carry;
  logic             Overflow;

  modport master (
    output Start, SrcA, SrcB, ALUCtr,
    input  Busy, Done, ALURes, Zero, Carry, Overflow
  );

  modport slave (
    input  Start, SrcA, SrcB, ALUCtr,
    output Busy, Done, ALURes, Zero, Carry, Overflow
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit sequential ALU, Start/Busy/Done handshake, iterative multiply/divide.
// Build option ALU_SEQ_DIV_EN: when defined, DIVU/REMU use a restoring divider (DIV state).
//
// state | meaning
// IDLE  | accepts Start; finishes a captured single-cycle op one cycle later
// MUL   | shift-add multiply, one multiplier bit per cycle, then result
// DIV   | restoring divide, one quotient bit per cycle, then result
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_NOR   = 4'b1100;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;
`endif

  typedef enum logic [1:0] {
    IDLE,
    MUL
`ifdef ALU_SEQ_DIV_EN
    , DIV
`endif
  } state_t;

  state_t             state, next_state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc, mul_next;
  logic [CW-1:0]      cnt;
  logic               pend;
  logic [WIDTH-1:0]   res_q;
  logic               done_q, zero_q, carry_q, ovf_q;
  logic               accept, multi, fin, fin_c, fin_v;
  logic [WIDTH-1:0]   fin_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   mul_wide;
`ifdef ALU_SEQ_DIV_EN
  logic               div_op;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [2*WIDTH-1:0] div_next;
`endif

  // Returns {carry, overflow, result}; the divide case is only reached with a zero divisor.
  function automatic logic [WIDTH+1:0] calc(input logic [3:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             c, v;
    sum = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_SLL: r = a << b[SHW-1:0];
      OP_SRL: r = a >> b[SHW-1:0];
      OP_SLT: r = WIDTH'($signed(a) < $signed(b));
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
`ifdef ALU_SEQ_DIV_EN
      OP_DIVU: r = '1;
      OP_REMU: r = a;
`endif
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_q : {WIDTH{1'b0}})};
    mul_wide = {mul_sum, acc[WIDTH-1:0]};
    mul_next = mul_wide[2*WIDTH:1];
`ifdef ALU_SEQ_DIV_EN
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    if (rem_sh >= {1'b0, b_q}) div_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else                       div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
`endif
  end

  always_comb begin
    accept     = bus.Start && (state == IDLE);
    multi      = (bus.ALUCtr == OP_MUL) || (bus.ALUCtr == OP_MULHU);
`ifdef ALU_SEQ_DIV_EN
    div_op     = ((bus.ALUCtr == OP_DIVU) || (bus.ALUCtr == OP_REMU)) && (bus.SrcB != '0);
    multi      = multi || div_op;
`endif
    next_state = state;
    fin        = 1'b0;
    fin_res    = '0;
    fin_c      = 1'b0;
    fin_v      = 1'b0;
    if (pend) begin
      {fin_c, fin_v, fin_res} = calc(op_q, a_q, b_q);
      fin = 1'b1;
    end
    case (state)
      IDLE: if (accept && multi) begin
        next_state = MUL;
`ifdef ALU_SEQ_DIV_EN
        if (div_op) next_state = DIV;
`endif
      end
      MUL: if (cnt == '0) begin
        fin        = 1'b1;
        fin_res    = (op_q == OP_MULHU) ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
        next_state = IDLE;
      end
`ifdef ALU_SEQ_DIV_EN
      DIV: if (cnt == '0) begin
        fin        = 1'b1;
        fin_res    = (op_q == OP_REMU) ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
        next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      pend    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pend   <= accept && !multi;
      done_q <= fin;
      if (fin) begin
        res_q   <= fin_res;
        zero_q  <= (fin_res == '0);
        carry_q <= fin_c;
        ovf_q   <= fin_v;
      end
      if (accept) begin
        op_q <= bus.ALUCtr;
        a_q  <= bus.SrcA;
        b_q  <= bus.SrcB;
        cnt  <= CW'(WIDTH);
        // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
        acc  <= {{WIDTH{1'b0}}, bus.SrcB};
`ifdef ALU_SEQ_DIV_EN
        if (div_op) acc <= {{WIDTH{1'b0}}, bus.SrcA};
`endif
      end else if ((state == MUL) && (cnt != '0)) begin
        acc <= mul_next;
        cnt <= cnt - CW'(1);
      end
`ifdef ALU_SEQ_DIV_EN
      else if ((state == DIV) && (cnt != '0)) begin
        acc <= div_next;
        cnt <= cnt - CW'(1);
      end
`endif
    end
  end

  assign bus.Busy     = (state != IDLE);
  assign bus.Done     = done_q;
  assign bus.ALURes   = res_q;
  assign bus.Zero     = zero_q;
  assign bus.Carry    = carry_q;
  assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_single(input string tag, input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] exp_res,
                            input logic exp_c, input logic exp_v);
    logic exp_z;
    exp_z      = (exp_res == 8'h00);
    bus.ALUCtr = op;
    bus.SrcA   = a;
    bus.SrcB   = b;
    bus.Start  = 1'b1;
    tick();
    bus.Start  = 1'b0;
    chk({tag, "_lat0"}, 32'(bus.Done), 32'd0);
    chk({tag, "_busy"}, 32'(bus.Busy), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(bus.Done), 32'd1);
    chk({tag, "_res"}, 32'(bus.ALURes), 32'(exp_res));
    chk({tag, "_zero"}, 32'(bus.Zero), 32'(exp_z));
    chk({tag, "_carry"}, 32'(bus.Carry), 32'(exp_c));
    chk({tag, "_ovf"}, 32'(bus.Overflow), 32'(exp_v));
  endtask

  // Issues a multi-cycle op, pokes a Start in the middle, expects Done 9 cycles after Start.
  task automatic run_multi(input string tag, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp_res);
    logic exp_z;
    exp_z      = (exp_res == 8'h00);
    bus.ALUCtr = op;
    bus.SrcA   = a;
    bus.SrcB   = b;
    bus.Start  = 1'b1;
    tick();
    bus.Start  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        bus.Start  = 1'b1;
        bus.ALUCtr = 4'b0010;
        bus.SrcA   = 8'h01;
        bus.SrcB   = 8'h01;
      end
      if (k == 5) bus.Start = 1'b0;
      tick();
      chk($sformatf("%s_busy%0d", tag, k), 32'(bus.Busy), 32'd1);
      chk($sformatf("%s_nodone%0d", tag, k), 32'(bus.Done), 32'd0);
    end
    tick();
    chk({tag, "_done"}, 32'(bus.Done), 32'd1);
    chk({tag, "_busy_off"}, 32'(bus.Busy), 32'd0);
    chk({tag, "_res"}, 32'(bus.ALURes), 32'(exp_res));
    chk({tag, "_zero"}, 32'(bus.Zero), 32'(exp_z));
    chk({tag, "_carry"}, 32'(bus.Carry), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.Overflow), 32'd0);
    tick();
    chk({tag, "_no_extra"}, 32'(bus.Done), 32'd0);
    chk({tag, "_hold"}, 32'(bus.ALURes), 32'(exp_res));
  endtask

  initial begin
    rst        = 1'b1;
    bus.Start  = 1'b0;
    bus.SrcA   = 8'h00;
    bus.SrcB   = 8'h00;
    bus.ALUCtr = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_res", 32'(bus.ALURes), 32'h00);
    chk("rst_zero", 32'(bus.Zero), 32'd1);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_carry", 32'(bus.Carry), 32'd0);
    chk("rst_ovf", 32'(bus.Overflow), 32'd0);

    // Start held high: AND, OR, ADD issued on consecutive edges
    bus.SrcA   = 8'hF0;
    bus.SrcB   = 8'h05;
    bus.ALUCtr = 4'b0000;
    bus.Start  = 1'b1;
    tick();
    chk("b2b_lat0", 32'(bus.Done), 32'd0);
    bus.ALUCtr = 4'b0001;
    tick();
    chk("b2b_and_done", 32'(bus.Done), 32'd1);
    chk("b2b_and_res", 32'(bus.ALURes), 32'h00);
    chk("b2b_and_zero", 32'(bus.Zero), 32'd1);
    bus.ALUCtr = 4'b0010;
    tick();
    chk("b2b_or_done", 32'(bus.Done), 32'd1);
    chk("b2b_or_res", 32'(bus.ALURes), 32'hF5);
    chk("b2b_or_zero", 32'(bus.Zero), 32'd0);
    bus.Start = 1'b0;
    tick();
    chk("b2b_add_done", 32'(bus.Done), 32'd1);
    chk("b2b_add_res", 32'(bus.ALURes), 32'hF5);
    chk("b2b_add_carry", 32'(bus.Carry), 32'd0);
    chk("b2b_add_busy", 32'(bus.Busy), 32'd0);
    tick();
    chk("b2b_idle_done", 32'(bus.Done), 32'd0);

    run_single("add_ovf", 4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    run_single("add_carry", 4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_single("sub_eq", 4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0);
    run_single("sub_borrow", 4'b0110, 8'h05, 8'h06, 8'hFF, 1'b0, 1'b0);
    run_single("sub_ovf", 4'b0110, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    run_single("slt", 4'b0111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0);
    run_single("slt_false", 4'b0111, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0);
    run_single("xor", 4'b0011, 8'hF0, 8'h55, 8'hA5, 1'b0, 1'b0);
    run_single("nor", 4'b1100, 8'hF0, 8'h05, 8'h0A, 1'b0, 1'b0);
    run_single("sll", 4'b0100, 8'h81, 8'h09, 8'h02, 1'b0, 1'b0);
    run_single("srl", 4'b0101, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0);
    run_single("rsvd", 4'b1111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

    run_multi("mul", 4'b1000, 8'h0F, 8'h11, 8'hFF);
    run_multi("mulhu", 4'b1001, 8'hFF, 8'hFF, 8'hFE);

`ifdef ALU_SEQ_DIV_EN
    run_multi("divu", 4'b1010, 8'hF0, 8'h05, 8'h30);
    run_multi("remu", 4'b1011, 8'hF3, 8'h05, 8'h03);
    run_single("divu_z", 4'b1010, 8'h12, 8'h00, 8'hFF, 1'b0, 1'b0);
    run_single("remu_z", 4'b1011, 8'h12, 8'h00, 8'h12, 1'b0, 1'b0);
`else
    run_single("divu_off", 4'b1010, 8'hF0, 8'h05, 8'h00, 1'b0, 1'b0);
    run_single("remu_off", 4'b1011, 8'hF3, 8'h05, 8'h00, 1'b0, 1'b0);
    run_single("divu_z_off", 4'b1010, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0);
`endif

    // Reset in the middle of a multiply: Busy drops, no Done follows
    run_single("pre_rst", 4'b0001, 8'h3C, 8'h00, 8'h3C, 1'b0, 1'b0);
    bus.ALUCtr = 4'b1000;
    bus.SrcA   = 8'h03;
    bus.SrcB   = 8'h05;
    bus.Start  = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    tick();
    chk("mid_busy", 32'(bus.Busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(bus.Busy), 32'd0);
    chk("abort_done", 32'(bus.Done), 32'd0);
    chk("abort_res", 32'(bus.ALURes), 32'h00);
    chk("abort_zero", 32'(bus.Zero), 32'd1);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("abort_quiet%0d", k), 32'(bus.Done), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for the h_CPU datapath: generalises the 8-bit combinational ALU to WIDTH bits and adds registered results, a Start/Busy/Done handshake, signed-overflow and carry flags, and iterative multiply and divide. It sits in the execute stage. The control unit issues one operation with Start and stalls while Busy is high.

## Interface
- WIDTH, 8: operand/result width, ≥4, power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- Start  in  1  issue request; sampled only when Busy=0.
- SrcA  in  WIDTH  operand A, captured on accepted Start.
- SrcB  in  WIDTH  operand B, captured on accepted Start.
- ALUCtr  in  4  operation select, captured on accepted Start.
- Busy  out  1  multi-cycle operation in progress.
- Done  out  1  one-cycle pulse: ALURes/flags updated this cycle.
- ALURes  out  WIDTH  registered result, held until next Done.
- Zero  out  1  ALURes == 0, registered with ALURes.
- Carry  out  1  carry-out for ADD, inverted borrow for SUB; 0 otherwise.
- Overflow  out  1  two's-complement overflow for ADD/SUB; 0 otherwise.

## Operation
- ALUCtr encodings: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed, result 1/0), 1000 MUL (low WIDTH of unsigned product), 1001 MULHU (high WIDTH), 1010 DIVU (quotient), 1011 REMU (remainder), 1100 NOR, 1101/1110/1111 reserved → ALURes=0, flags 0, single-cycle.
- Shifts use SrcB[SHW-1:0]; upper bits ignored.
- All arithmetic is modulo 2^WIDTH; Carry = bit WIDTH of the (WIDTH+1)-bit sum; SUB computed as A + ~B + 1.
- FSM states: IDLE, MUL, DIV.
- IDLE + Start + single-cycle op: compute, register result, pulse Done next cycle; stay IDLE.
- IDLE + Start + MUL/MULHU: load multiplicand, multiplier, 2·WIDTH accumulator, counter=WIDTH → MUL. Shift-add one bit per cycle. Counter 0 → register selected half, pulse Done → IDLE.
- IDLE + Start + DIVU/REMU: SrcB==0 → no DIV entry; quotient = all ones, remainder = SrcA, Done next cycle. Otherwise restoring division, one bit per cycle, WIDTH cycles → DIV → IDLE.
- Start while Busy=1 is ignored (no queueing, no error).
- Zero computed from the final ALURes for every op. Carry/Overflow are 0 for non-ADD/SUB ops.

## Timing
- Reset (rst high at an edge): state IDLE; Busy=0, Done=0, ALURes=0, Zero=1, Carry=0, Overflow=0; counters and operand registers cleared. Reset mid-operation aborts it with no Done.
- Single-cycle op: Start sampled at edge N → Done=1 and result valid after edge N+1 (latency 1); Busy stays 0.
- MUL/MULHU/DIVU/REMU (divisor ≠ 0): Busy high from edge N+1 to edge N+WIDTH. Done and result after edge N+WIDTH+1 (latency WIDTH+1). Busy is 0 in the Done cycle.
- Back-to-back: Start may be asserted in the Done cycle and is accepted, giving one issue per cycle for single-cycle ops.
- Operand inputs may change freely after acceptance; internal copies are used.

## Configuration
- ALU_SEQ_DIV_EN defined: DIVU/REMU implemented as above; DIV state present.
- ALU_SEQ_DIV_EN undefined: divider logic and DIV state removed. DIVU/REMU behave as reserved codes: ALURes=0, Zero=1, single-cycle Done.

## Test plan
- Reset then idle: ALURes=0x00, Zero=1, Busy=0, Done=0. Assert rst during MUL: Busy drops after that edge, no Done.
- WIDTH=8: SrcA=0xF0, SrcB=0x05; ALUCtr 0000/0001/0010 → 0x00 (Zero=1) / 0xF5 / 0xF5, each Done one cycle after Start. Start held high issues each op back-to-back.
- ADD 0x7F+0x01 → 0x80, Overflow=1, Carry=0. ADD 0xFF+0x01 → 0x00, Carry=1, Zero=1. SUB 0x05−0x05 → 0x00, Carry=1. SLT 0x80,0x01 → 0x01.
- MUL 0x0F×0x11 → 0xFF, MULHU 0xFF×0xFF → 0xFE. Done exactly 9 cycles after Start, Busy high 8 cycles; a Start mid-operation is ignored.
- DIVU 0xF0/0x05 → 0x30, REMU 0xF3/0x05 → 0x03 with latency 9. DIVU 0x12/0x00 → 0xFF and REMU → 0x12, latency 1. With ALU_SEQ_DIV_EN undefined, both → 0x00, latency 1.
- SLL 0x81 by SrcB=0x09 (amount 1) → 0x02. SRL 0x80 by 7 → 0x01. Reserved code 1111 → 0x00, Zero=1.
